i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 117 +++++++++++
 tb/tb_i2s_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Summary  : I2S transmitter, 16-bit stereo in 32-bit slots, with a one-pair
//            holding buffer and an underrun pulse.
// Revision : 1.0
// ============================================================================
module i2s_tx #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] left,
    input  logic [15:0] right,
    input  logic        valid,
    output logic        ready,
    output logic        sclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun
);

    localparam logic [7:0] c_div_last = 8'(DIV - 1);

    logic [7:0]  r_div_cnt;
    logic [5:0]  r_bit_cnt;
    logic        r_sclk;
    logic        r_lrclk;
    logic        r_sdata;
    logic        r_underrun;
    logic        r_full;
    logic [15:0] r_buf_l;
    logic [15:0] r_buf_r;
    logic [15:0] r_act_l;
    logic [15:0] r_act_r;

    logic        w_tick;
    logic        w_fall;
    logic        w_wrap;
    logic        w_xfer;
    logic [5:0]  w_bit_nxt;
    logic [4:0]  w_pos;
    logic [3:0]  w_idx;
    logic [15:0] w_sample;
    logic        w_bit;

    assign w_tick    = (r_div_cnt == c_div_last);
    assign w_fall    = w_tick & r_sclk;
    assign w_wrap    = w_fall & (r_bit_cnt == 6'd63);
    assign w_xfer    = valid & ~r_full;
    assign w_bit_nxt = r_bit_cnt + 6'd1;
    assign w_pos     = w_bit_nxt[4:0];
    // Slot position p maps to sample bit 16-p, i.e. ~(p-1) in four bits.
    assign w_idx     = ~(w_pos[3:0] - 4'd1);

    // Outputs are registered for the slot being entered, so the serial bit
    // is looked up from the next bit counter value.
    always_comb begin
        w_sample = w_bit_nxt[5] ? r_act_r : r_act_l;
        w_bit    = 1'b0;
        if ((w_pos != 5'd0) && (w_pos <= 5'd16)) begin
            w_bit = w_sample[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt  <= 8'd0;
            r_bit_cnt  <= 6'd0;
            r_sclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
            r_full     <= 1'b0;
            r_buf_l    <= 16'd0;
            r_buf_r    <= 16'd0;
            r_act_l    <= 16'd0;
            r_act_r    <= 16'd0;
        end else begin
            r_underrun <= 1'b0;
            r_div_cnt  <= w_tick ? 8'd0 : r_div_cnt + 8'd1;
            if (w_tick) begin
                r_sclk <= ~r_sclk;
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrclk   <= w_bit_nxt[5];
                r_sdata   <= w_bit;
            end
            if (w_wrap) begin
                if (r_full) begin
                    r_act_l <= r_buf_l;
                    r_act_r <= r_buf_r;
                end else begin
                    r_underrun <= 1'b1;
                end
            end
            // A frame load and a new transfer never both touch the buffer:
            // a transfer requires full==0, a load only drains when full==1.
            if (w_wrap && r_full) begin
                r_full <= 1'b0;
            end else if (w_xfer) begin
                r_full  <= 1'b1;
                r_buf_l <= left;
                r_buf_r <= right;
            end
        end
    end

    assign ready    = ~r_full;
    assign sclk     = r_sclk;
    assign lrclk    = r_lrclk;
    assign sdata    = r_sdata;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx
// Summary  : Scoreboard bench for i2s_tx: frames and underrun counts are
//            queued by the stimulus and checked by a frame monitor.
// Revision : 1.0
// ============================================================================
module tb_i2s_tx;

    localparam int DIV   = 4;
    localparam int FRAME = 128 * DIV;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] left  = 16'd0;
    logic [15:0] right = 16'd0;
    logic        ready;
    logic        sclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] bits;
        int          ur;
    } exp_t;

    exp_t exp_q[$];

    i2s_tx #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .left     (left),
        .right    (right),
        .valid    (valid),
        .ready    (ready),
        .sclk     (sclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc=%0d)", nm, act, req, cyc);
        end
    endtask

    // Slot word as seen on sclk rising edges: delay bit, 16 data bits, 15 pad bits.
    function automatic logic [63:0] frame_bits(input logic [15:0] l, input logic [15:0] r);
        return {1'b0, l, 15'd0, 1'b0, r, 15'd0};
    endfunction

    task automatic expect_frame(input logic [63:0] b, input int ur);
        exp_t e;
        e.bits = b;
        e.ur   = ur;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] l, input logic [15:0] r, output int acc);
        acc   = -1;
        left  = l;
        right = r;
        valid = 1'b1;
        for (int n = 0; (n < 2000) && (acc < 0); n++) begin
            if (ready) acc = cyc + 1;
            @(negedge clk);
        end
        valid = 1'b0;
        if (acc < 0) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no ready want ready within 2000 cycles");
        end
    endtask

    // Frame monitor: collects 64 sdata bits per frame and the underrun pulses
    // seen since the previous frame ended, then checks them against the queue.
    int          m_rc;
    int          m_ur;
    logic [63:0] m_word;
    logic        m_ps;
    exp_t        m_e;

    always @(negedge clk) begin
        if (rst) begin
            m_rc   = 0;
            m_ur   = 0;
            m_word = '0;
            m_ps   = 1'b0;
        end else begin
            if (underrun) m_ur++;
            if (sclk && !m_ps) begin
                chk("lrclk_slot", 64'(lrclk), 64'((m_rc % 64) >= 32));
                m_word = {m_word[62:0], sdata};
                if ((m_rc % 64) == 63) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL frame_unexpected: got frame %0d want none queued", m_rc / 64);
                    end else begin
                        m_e = exp_q.pop_front();
                        chk($sformatf("frame%0d_bits", m_rc / 64), m_word, m_e.bits);
                        chk($sformatf("frame%0d_underrun", m_rc / 64), 64'(m_ur), 64'(m_e.ur));
                    end
                    m_ur = 0;
                end
                m_rc++;
            end
            m_ps = sclk;
        end
    end

    // Clock shape checker: sclk period/duty, lrclk period and edge alignment.
    int   k_rise;
    int   k_lr;
    logic k_rise_ok;
    logic k_lr_ok;
    logic k_ps;
    logic k_pl;

    always @(negedge clk) begin
        if (rst) begin
            k_rise    = 0;
            k_lr      = 0;
            k_rise_ok = 1'b0;
            k_lr_ok   = 1'b0;
            k_ps      = 1'b0;
            k_pl      = 1'b0;
        end else begin
            k_rise++;
            k_lr++;
            if (sclk && !k_ps) begin
                if (k_rise_ok) chk("sclk_period", 64'(k_rise), 64'(2 * DIV));
                k_rise_ok = 1'b1;
                k_rise    = 0;
            end
            if (!sclk && k_ps && k_rise_ok) chk("sclk_high", 64'(k_rise), 64'(DIV));
            if (lrclk != k_pl) chk("lrclk_on_sclk_fall", 64'(k_ps && !sclk), 64'd1);
            if (lrclk && !k_pl) begin
                if (k_lr_ok) chk("lrclk_period", 64'(k_lr), 64'(FRAME));
                k_lr_ok = 1'b1;
                k_lr    = 0;
            end
            k_ps = sclk;
            k_pl = lrclk;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        repeat (3) @(negedge clk);
        chk("rst_ready",    64'(ready),    64'd1);
        chk("rst_sclk",     64'(sclk),     64'd0);
        chk("rst_lrclk",    64'(lrclk),    64'd0);
        chk("rst_sdata",    64'(sdata),    64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        rst = 1'b0;
        expect_frame(64'd0, 0);

        // Single pair during frame 0, then repeated frames with underrun.
        wait_cyc(99);
        send(16'hA55A, 16'h8001, acc);
        chk("pair_accept_cyc", 64'(acc), 64'd100);
        expect_frame(64'h52AD0000_40008000, 0);
        expect_frame(64'h52AD0000_40008000, 1);
        expect_frame(64'h52AD0000_40008000, 1);

        // Backpressure: P1 accepted at once, P2 waits for the next load.
        wait_cyc(3 * FRAME + 99);
        send(16'h1234, 16'hFEDC, acc);
        chk("p1_accept_cyc", 64'(acc), 64'(3 * FRAME + 100));
        chk("p1_ready_low", 64'(ready), 64'd0);
        send(16'h7FFF, 16'h8000, acc);
        chk("p2_accept_cyc", 64'(acc), 64'(4 * FRAME + 1));
        expect_frame(frame_bits(16'h1234, 16'hFEDC), 0);
        expect_frame(frame_bits(16'h7FFF, 16'h8000), 0);

        // Transfer on the exact wrap edge with the buffer empty.
        wait_cyc(6 * FRAME - 1);
        send(16'h0F0F, 16'hF0F0, acc);
        chk("p3_accept_cyc", 64'(acc), 64'(6 * FRAME));
        chk("p3_underrun", 64'(underrun), 64'd1);
        chk("p3_ready_low", 64'(ready), 64'd0);
        expect_frame(frame_bits(16'h7FFF, 16'h8000), 1);
        expect_frame(frame_bits(16'h0F0F, 16'hF0F0), 0);

        // Mid-frame reset at bit_cnt=20 with a pair buffered.
        wait_cyc(8 * FRAME + 50);
        send(16'hDEAD, 16'hBEEF, acc);
        chk("p4_accept_cyc", 64'(acc), 64'(8 * FRAME + 51));
        chk("p4_buffered", 64'(ready), 64'd0);
        wait_cyc(8 * FRAME + 10 * 2 * DIV * 2 + 5);
        chk("pre_reset_sclk", 64'(sclk), 64'd1);
        chk("pre_reset_queue", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_sclk",  64'(sclk),  64'd0);
        chk("mid_rst_lrclk", 64'(lrclk), 64'd0);
        chk("mid_rst_sdata", 64'(sdata), 64'd0);
        chk("mid_rst_ready", 64'(ready), 64'd1);
        rst = 1'b0;
        expect_frame(64'd0, 0);
        expect_frame(64'd0, 1);
        wait_cyc(2 * FRAME + 8);
        chk("epoch2_queue", 64'(exp_q.size()), 64'd0);

        // Transfer in the very first cycle after reset is released.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_frame(64'd0, 0);
        expect_frame(frame_bits(16'h5555, 16'hAAAA), 0);
        send(16'h5555, 16'hAAAA, acc);
        chk("p5_accept_cyc", 64'(acc), 64'd1);
        wait_cyc(2 * FRAME + 8);
        chk("epoch3_queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
